// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the pipelined core. It registers the decoded
// operands and control that EX needs, and it detects load-use hazards.
// When a hazard is found it loads a bubble and stalls the front end. It also
// obeys branch flush from EX and hold requests from downstream.
//
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add a saturating
// bubble_cnt output. The counter increments on every edge that loads a
// bubble, whether from a flush or from a load-use hazard.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_uses_rs2,
    input  logic [2:0]         id_funct3,
    input  logic [1:0]         id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [2:0]         ex_funct3,
    output logic [1:0]         ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0]   bubble_cnt,
`endif
    output logic               id_stall
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [2:0]         funct3;
        logic [1:0]         alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ex_slot_t;

    ex_slot_t r_ex;
    ex_slot_t w_nxt;
    logic     w_load_use;
    logic     w_bubble;

    // A load in EX whose destination is a source of the ID instruction.
    // A load that targets x0 never creates a dependency.
    assign w_load_use = r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) & id_valid &
                        ((r_ex.rd == id_rs1) | (id_uses_rs2 & (r_ex.rd == id_rs2)));

    // A flush lets the branch in EX complete, so it never asks for a stall.
    // Gating with rst_n keeps the stall low while the stage is held in reset.
    assign id_stall = rst_n & ~flush & (ex_hold | w_load_use);

    // Next slot contents: flush > hold > load-use bubble > normal capture.
    always_comb begin
        w_nxt    = r_ex;
        w_bubble = 1'b0;
        if (flush) begin
            w_nxt    = '0;
            w_bubble = 1'b1;
        end else if (ex_hold) begin
            w_nxt    = r_ex;
        end else if (w_load_use) begin
            w_nxt    = '0;
            w_bubble = 1'b1;
        end else begin
            w_nxt.valid      = id_valid;
            w_nxt.pc         = id_pc;
            w_nxt.rs1_data   = id_rs1_data;
            w_nxt.rs2_data   = id_rs2_data;
            w_nxt.imm        = id_imm;
            w_nxt.rs1        = id_rs1;
            w_nxt.rs2        = id_rs2;
            w_nxt.rd         = id_rd;
            w_nxt.funct3     = id_funct3;
            w_nxt.alu_op     = id_alu_op;
            // An empty ID slot must never write memory or the register file.
            w_nxt.alu_src    = id_alu_src    & id_valid;
            w_nxt.mem_read   = id_mem_read   & id_valid;
            w_nxt.mem_write  = id_mem_write  & id_valid;
            w_nxt.reg_write  = id_reg_write  & id_valid;
            w_nxt.mem_to_reg = id_mem_to_reg & id_valid;
        end
    end

    // ---- ID -> EX boundary ----
    // Pipeline register; cleared asynchronously, so EX sees a bubble at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_nxt;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_pc         = r_ex.pc;
    assign ex_rs1_data   = r_ex.rs1_data;
    assign ex_rs2_data   = r_ex.rs2_data;
    assign ex_imm        = r_ex.imm;
    assign ex_rs1        = r_ex.rs1;
    assign ex_rs2        = r_ex.rs2;
    assign ex_rd         = r_ex.rd;
    assign ex_funct3     = r_ex.funct3;
    assign ex_alu_op     = r_ex.alu_op;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_mem_to_reg = r_ex.mem_to_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;

    // Count inserted bubbles and stick at all-ones; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    // Without the counter, the bubble strobe and CNT_W have no load.
    logic [CNT_W:0] w_unused_cnt;
    assign w_unused_cnt = {CNT_W'(0), w_bubble};
`endif

endmodule
